arb_rr_pushpop: RTL and testbench

- Round-robin arbiter that drives the `arb_pop`/`arb_push` one-hot controls consumed by the FIFO mux/demux datapath.
- Watches four source-FIFO heads and picks one eligible head per cycle.
- Decodes that head's destination from bits [WORD_SIZE-1:WORD_SIZE-2].
- Issues a registered pop to the source, a push to the destination FIFO, and forwards the word.

---
 rtl/arb_rr_pushpop_pkg.sv | 12 +
 rtl/arb_rr_pushpop_rr_priority_sel.sv | 18 +
 rtl/arb_rr_pushpop.sv | 94 +++++++++
 tb/tb_arb_rr_pushpop.sv | 104 ++++++++++
 4 files changed

// File: rtl/arb_rr_pushpop_pkg.sv
// arb_defs: shared constants, destination type and one-hot helper for the round-robin push/pop arbiter.
package arb_defs;
  localparam int FIFO_UNITS = 4;
  localparam int WORD_SIZE = 10;
  localparam int DEST_MSB = WORD_SIZE - 1;
  localparam int DEST_LSB = WORD_SIZE - 2;
  typedef logic [1:0] dest_t;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [3:0] onehot4(dest_t d);
    return 4'b0001 << d;
  endfunction
endpackage

// File: rtl/arb_rr_pushpop_rr_priority_sel.sv
// rr_priority_sel: combinational rotate-priority picker; first eligible index at or after rr_ptr (mod 4).
module rr_priority_sel
  import arb_defs::*;
(
  input  logic [3:0] i_eligible,
  input  dest_t      i_rr_ptr,
  output logic       o_grant_valid,
  output dest_t      o_g
);
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  dest_t      w_ofs;
  assign w_dbl = {i_eligible, i_eligible};
  assign w_rot = 4'(w_dbl >> i_rr_ptr);
  assign w_ofs = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_g = i_rr_ptr + w_ofs;
  assign o_grant_valid = |i_eligible;
endmodule

// File: rtl/arb_rr_pushpop.sv
// arb_rr_pushpop: round-robin arbiter issuing registered one-hot pop/push and forwarding the granted head word.
// Optional per-destination saturating push counters when ARB_PKT_COUNT_EN is defined.
module arb_rr_pushpop
  import arb_defs::*;
#(
  parameter int FIFO_UNITS = arb_defs::FIFO_UNITS,
  parameter int WORD_SIZE = arb_defs::WORD_SIZE,
  parameter int PTR_L = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [FIFO_UNITS-1:0] fifo_empty,
  input  logic [FIFO_UNITS-1:0] fifo_almost_full,
  input  logic [WORD_SIZE-1:0]  fifo_data_in0,
  input  logic [WORD_SIZE-1:0]  fifo_data_in1,
  input  logic [WORD_SIZE-1:0]  fifo_data_in2,
  input  logic [WORD_SIZE-1:0]  fifo_data_in3,
  output logic [FIFO_UNITS-1:0] arb_pop,
  output logic [FIFO_UNITS-1:0] arb_push,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  idle
`ifdef ARB_PKT_COUNT_EN
  ,output logic [7:0]           pkt_count0,
  output logic [7:0]            pkt_count1,
  output logic [7:0]            pkt_count2,
  output logic [7:0]            pkt_count3
`endif
);
  // The 2-bit destination field ties the unit count to four.
  if (FIFO_UNITS != 4 || PTR_L < 1) begin : g_bad_cfg
    $error("arb_rr_pushpop supports exactly 4 FIFO units");
  end
  logic [WORD_SIZE-1:0]  w_head [4];
  dest_t                 w_dest [4];
  logic [3:0]            w_elig;
  logic                  w_valid;
  dest_t                 w_g;
  logic [3:0]            w_push_nxt;
  state_t                r_state, w_state_nxt;
  logic [FIFO_UNITS-1:0] r_pop, r_push;
  logic [WORD_SIZE-1:0]  r_data;
  dest_t                 r_ptr;
  assign w_head[0] = fifo_data_in0;
  assign w_head[1] = fifo_data_in1;
  assign w_head[2] = fifo_data_in2;
  assign w_head[3] = fifo_data_in3;
  // A source popped this cycle still shows its old head, so it sits out one decision.
  for (genvar i = 0; i < 4; i++) begin : g_elig
    assign w_dest[i] = w_head[i][WORD_SIZE-1:WORD_SIZE-2];
    assign w_elig[i] = !fifo_empty[i] && !r_pop[i] && !fifo_almost_full[w_dest[i]];
  end
  rr_priority_sel u_sel (
    .i_eligible   (w_elig),
    .i_rr_ptr     (r_ptr),
    .o_grant_valid(w_valid),
    .o_g          (w_g)
  );
  assign w_push_nxt = w_valid ? onehot4(w_dest[w_g]) : 4'b0000;
  always_comb w_state_nxt = w_valid ? BUSY : IDLE;
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_pop   <= '0;
      r_push  <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= w_valid ? onehot4(w_g) : '0;
      r_push  <= w_push_nxt;
      if (w_valid) begin
        r_data <= w_head[w_g];
        r_ptr  <= w_g + 2'd1;
      end
    end
  end
  assign arb_pop  = r_pop;
  assign arb_push = r_push;
  assign data_out = r_data;
  assign idle     = (r_state == IDLE);
`ifdef ARB_PKT_COUNT_EN
  logic [7:0] r_cnt [4];
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (!reset_L) r_cnt[j] <= '0;
      else if (w_push_nxt[j] && r_cnt[j] != 8'hff) r_cnt[j] <= r_cnt[j] + 8'd1;
    end
  end
  assign pkt_count0 = r_cnt[0];
  assign pkt_count1 = r_cnt[1];
  assign pkt_count2 = r_cnt[2];
  assign pkt_count3 = r_cnt[3];
`endif
endmodule

// File: tb/tb_arb_rr_pushpop.sv
// tb_arb_rr_pushpop: directed vectors with hand-computed expectations for arb_rr_pushpop.
module tb_arb_rr_pushpop;
  logic       clk = 0;
  logic       reset_L;
  logic [3:0] fifo_empty, fifo_almost_full;
  logic [9:0] d0, d1, d2, d3;
  logic [3:0] arb_pop, arb_push;
  logic [9:0] data_out;
  logic       idle;
  int         n_tests = 0;
  int         n_fail = 0;
`ifdef ARB_PKT_COUNT_EN
  logic [7:0] pc0, pc1, pc2, pc3;
`endif
  arb_rr_pushpop dut (
    .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .fifo_data_in0(d0), .fifo_data_in1(d1), .fifo_data_in2(d2), .fifo_data_in3(d3),
    .arb_pop(arb_pop), .arb_push(arb_push), .data_out(data_out), .idle(idle)
`ifdef ARB_PKT_COUNT_EN
    , .pkt_count0(pc0), .pkt_count1(pc1), .pkt_count2(pc2), .pkt_count3(pc3)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [3:0] pop, input logic [3:0] push, input logic [9:0] data, input logic idl);
    check({tag, ".pop"}, 32'(arb_pop), 32'(pop));
    check({tag, ".push"}, 32'(arb_push), 32'(push));
    check({tag, ".data"}, 32'(data_out), 32'(data));
    check({tag, ".idle"}, 32'(idle), 32'(idl));
  endtask
  task automatic do_reset();
    reset_L = 0;
    step();
    reset_L = 1;
  endtask
  initial begin
    reset_L = 0;
    fifo_empty = 4'b0000;
    fifo_almost_full = 4'b0000;
    d0 = 10'h311; d1 = 10'h222; d2 = 10'h133; d3 = 10'h044;
    // reset held two cycles with every source non-empty
    step(); expect_out("rst1", 4'b0000, 4'b0000, 10'h000, 1'b1);
    step(); expect_out("rst2", 4'b0000, 4'b0000, 10'h000, 1'b1);
    // single source FIFO2, head 0x105 -> dest 1
    fifo_empty = 4'b1011; d2 = 10'h105;
    reset_L = 1;
    step(); expect_out("single1", 4'b0100, 4'b0010, 10'h105, 1'b0);
    step(); expect_out("single2", 4'b0000, 4'b0000, 10'h105, 1'b1);
    step(); expect_out("single3", 4'b0100, 4'b0010, 10'h105, 1'b0);
    // rotation, heads dest 3,2,1,0
    d2 = 10'h133; fifo_empty = 4'b0000;
    do_reset();
    step(); expect_out("rot1", 4'b0001, 4'b1000, 10'h311, 1'b0);
    step(); expect_out("rot2", 4'b0010, 4'b0100, 10'h222, 1'b0);
    step(); expect_out("rot3", 4'b0100, 4'b0010, 10'h133, 1'b0);
    step(); expect_out("rot4", 4'b1000, 4'b0001, 10'h044, 1'b0);
    step(); expect_out("rot5", 4'b0001, 4'b1000, 10'h311, 1'b0);
    // backpressure on dest 0 blocks only FIFO0
    do_reset();
    fifo_empty = 4'b1100; fifo_almost_full = 4'b0001;
    d0 = 10'h0AA; d1 = 10'h155;
    step(); expect_out("bp1", 4'b0010, 4'b0010, 10'h155, 1'b0);
    step(); expect_out("bp2", 4'b0000, 4'b0000, 10'h155, 1'b1);
    step(); expect_out("bp3", 4'b0010, 4'b0010, 10'h155, 1'b0);
    step(); expect_out("bp4", 4'b0000, 4'b0000, 10'h155, 1'b1);
    fifo_almost_full = 4'b0000;
    step(); expect_out("bp_clr", 4'b0001, 4'b0001, 10'h0AA, 1'b0);
    // reset mid-stream drops the in-flight transfer
    d0 = 10'h311; d1 = 10'h222; fifo_empty = 4'b0000;
    do_reset();
    step(); check("mid.pop1", 32'(arb_pop), 32'h1);
    step(); check("mid.pop2", 32'(arb_pop), 32'h2);
    reset_L = 0;
    step(); expect_out("mid.rst", 4'b0000, 4'b0000, 10'h000, 1'b1);
    reset_L = 1;
    step(); expect_out("mid.after", 4'b0001, 4'b1000, 10'h311, 1'b0);
`ifdef ARB_PKT_COUNT_EN
    // single source to dest 3: one push every other cycle, 300 pushes in 600 cycles
    do_reset();
    fifo_empty = 4'b1110; d0 = 10'h3C5;
    repeat (200) step();
    check("cnt3_100", 32'(pc3), 32'd100);
    repeat (400) step();
    check("cnt3_sat", 32'(pc3), 32'd255);
    check("cnt0", 32'(pc0), 32'd0);
    check("cnt1", 32'(pc1), 32'd0);
    check("cnt2", 32'(pc2), 32'd0);
    do_reset();
    check("cnt3_rst", 32'(pc3), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
